// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: frames three received bytes into one command and
// serialises 1- or 2-byte responses onto the byte transmitter.
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_byte,
    output logic        clr_rx_rdy,
    output logic        trmt,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic        cmd_vld,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_data,
    input  logic        cmd_ack,
    input  logic        resp_req,
    input  logic        resp_two,
    input  logic [15:0] resp_data,
    output logic        resp_busy,
    output logic        frm_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SEND_HI,
        TX_WAIT_HI,
        TX_SEND_LO,
        TX_WAIT_LO
    } tx_state_e;

    // ---------------- RX framing ----------------
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          clr_q, clr_d;
    logic          vld_q, vld_d;
    logic [7:0]    op_q, op_d;
    logic [15:0]   data_q, data_d;
    logic          frm_err_q, frm_err_d;
    logic          accept;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        vld_d     = vld_q;
        op_d      = op_q;
        data_d    = data_q;
        clr_d     = 1'b0;
        frm_err_d = 1'b0;

        // clr_q doubles as the guard: the receiver still shows rdy while it sees clr_rdy.
        accept = rx_rdy && !vld_q && !clr_q;

        if (vld_q && cmd_ack) begin
            vld_d = 1'b0;
        end

        if (accept) begin
            clr_d = 1'b1;
            tmo_d = '0;
            case (cnt_q)
                2'd0: begin
                    op_d  = rx_byte;
                    cnt_d = 2'd1;
                end
                2'd1: begin
                    data_d[15:8] = rx_byte;
                    cnt_d        = 2'd2;
                end
                default: begin
                    data_d[7:0] = rx_byte;
                    vld_d       = 1'b1;
                    cnt_d       = 2'd0;
                end
            endcase
        end else if (cnt_q != 2'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                cnt_d     = 2'd0;
                tmo_d     = '0;
                frm_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            tmo_q     <= '0;
            clr_q     <= 1'b0;
            vld_q     <= 1'b0;
            op_q      <= '0;
            data_q    <= '0;
            frm_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            clr_q     <= clr_d;
            vld_q     <= vld_d;
            op_q      <= op_d;
            data_q    <= data_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign clr_rx_rdy = clr_q;
    assign cmd_vld    = vld_q;
    assign cmd_op     = op_q;
    assign cmd_data   = data_q;
    assign frm_err    = frm_err_q;

    // ---------------- TX response FSM ----------------
    tx_state_e   state_q, state_d;
    logic        blank_q, blank_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  lo_q, lo_d;

    always_comb begin
        state_d   = state_q;
        blank_d   = blank_q;
        tx_byte_d = tx_byte_q;
        lo_d      = lo_q;
        trmt      = 1'b0;
        resp_busy = (state_q != TX_IDLE);

        case (state_q)
            TX_IDLE: begin
                if (resp_req) begin
                    lo_d = resp_data[7:0];
                    if (resp_two) begin
                        tx_byte_d = resp_data[15:8];
                        state_d   = TX_SEND_HI;
                    end else begin
                        tx_byte_d = resp_data[7:0];
                        state_d   = TX_SEND_LO;
                    end
                end
            end
            TX_SEND_HI: begin
                trmt    = 1'b1;
                blank_d = 1'b1;
                state_d = TX_WAIT_HI;
            end
            TX_WAIT_HI: begin
                // tx_done may still reflect the previous byte during the first wait cycle.
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (tx_done) begin
                    tx_byte_d = lo_q;
                    state_d   = TX_SEND_LO;
                end
            end
            TX_SEND_LO: begin
                trmt    = 1'b1;
                blank_d = 1'b1;
                state_d = TX_WAIT_LO;
            end
            TX_WAIT_LO: begin
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (tx_done) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // NOTE: only control and output flops need reset; lo_q is reset too so outputs never show stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            blank_q   <= 1'b0;
            tx_byte_q <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            blank_q   <= blank_d;
            tx_byte_q <= tx_byte_d;
            lo_q      <= lo_d;
        end
    end

    assign tx_byte = tx_byte_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios followed by
// randomized concurrent frame/response traffic against a byte-level model.
module tb_uart_cmd_ctrl;

    localparam int T     = 16;
    localparam int BOUND = 100;

    logic        clk;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_byte;
    logic        clr_rx_rdy;
    logic        trmt;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        cmd_vld;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        cmd_ack;
    logic        resp_req;
    logic        resp_two;
    logic [15:0] resp_data;
    logic        resp_busy;
    logic        frm_err;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_byte    (rx_byte),
        .clr_rx_rdy (clr_rx_rdy),
        .trmt       (trmt),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .cmd_vld    (cmd_vld),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ack    (cmd_ack),
        .resp_req   (resp_req),
        .resp_two   (resp_two),
        .resp_data  (resp_data),
        .resp_busy  (resp_busy),
        .frm_err    (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse counters sampled on the falling edge; read them #1 after a falling edge.
    int   trmt_cnt   = 0;
    int   clr_cnt    = 0;
    int   clr_double = 0;
    int   frm_cnt    = 0;
    logic clr_prev   = 1'b0;

    always @(negedge clk) begin
        if (trmt)                  trmt_cnt   <= trmt_cnt + 1;
        if (clr_rx_rdy)            clr_cnt    <= clr_cnt + 1;
        if (clr_rx_rdy && clr_prev) clr_double <= clr_double + 1;
        if (frm_err)               frm_cnt    <= frm_cnt + 1;
        clr_prev <= clr_rx_rdy;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({cmd_vld, clr_rx_rdy, trmt, resp_busy, frm_err}), 0);
        check({tag, "_data"}, {tx_byte, cmd_op, cmd_data}, 0);
    endtask

    // Receiver model: rdy stays up until one cycle after clr_rdy is seen.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_byte = b;
        rx_rdy  = 1'b1;
        k = 0;
        @(negedge clk);
        while (!clr_rx_rdy && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check("rx_accept", 32'(clr_rx_rdy), 1);
        @(negedge clk);
        check("clr_pulse_width", 32'(clr_rx_rdy), 0);
        rx_rdy  = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    task automatic expect_frame(input logic [7:0] op, input logic [15:0] data);
        check("frame_vld", 32'(cmd_vld), 1);
        check("frame_op", 32'(cmd_op), 32'(op));
        check("frame_data", 32'(cmd_data), 32'(data));
    endtask

    task automatic ack_cmd();
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check("ack_clears_vld", 32'(cmd_vld), 0);
    endtask

    // Drives one response and plays the transmitter (tx_done rests high between bytes).
    task automatic do_response(input logic two, input logic [15:0] data,
                               input logic poke, input logic start_now);
        logic [7:0] exp_b [2];
        int n;
        int k;
        n = two ? 2 : 1;
        exp_b[0] = two ? data[15:8] : data[7:0];
        exp_b[1] = data[7:0];
        if (!start_now) @(negedge clk);
        resp_req  = 1'b1;
        resp_two  = two;
        resp_data = data;
        @(negedge clk);
        resp_req  = 1'b0;
        resp_two  = 1'($urandom);
        resp_data = 16'($urandom);
        check("resp_busy_set", 32'(resp_busy), 1);
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (!trmt && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("trmt_latency", k, 0);
            check("trmt_seen", 32'(trmt), 1);
            check("tx_byte", 32'(tx_byte), 32'(exp_b[i]));
            @(negedge clk);
            check("trmt_one_cycle", 32'(trmt), 0);
            if (poke && i == 0) begin
                resp_req  = 1'b1;
                resp_two  = 1'b1;
                resp_data = 16'h5A5A;
            end
            @(negedge clk);
            resp_req = 1'b0;
            check("blanking", 32'({trmt, resp_busy}), 1);
            tx_done = 1'b0;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            check("tx_byte_stable", 32'(tx_byte), 32'(exp_b[i]));
            tx_done = 1'b1;
            @(negedge clk);
        end
        check("resp_done", 32'({trmt, resp_busy}), 0);
    endtask

    task automatic rand_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        send_byte(b0);
        repeat ($urandom_range(0, T / 2)) @(negedge clk);
        send_byte(b1);
        repeat ($urandom_range(0, T / 2)) @(negedge clk);
        send_byte(b2);
        expect_frame(b0, {b1, b2});
        repeat ($urandom_range(0, 4)) @(negedge clk);
        ack_cmd();
    endtask

    int c0;
    int t0;
    int f0;
    int w;

    initial begin
        rst       = 1'b1;
        rx_rdy    = 1'b0;
        rx_byte   = '0;
        tx_done   = 1'b1;
        cmd_ack   = 1'b0;
        resp_req  = 1'b0;
        resp_two  = 1'b0;
        resp_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Stray ack with nothing valid, then a framed command with gaps.
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check("stray_ack", 32'(cmd_vld), 0);
        #1;
        c0 = clr_cnt;
        send_byte(8'hA5);
        repeat (3) @(negedge clk);
        send_byte(8'h12);
        repeat (5) @(negedge clk);
        send_byte(8'h34);
        expect_frame(8'hA5, 16'h1234);
        #1;
        check("clr_pulses_frame1", clr_cnt - c0, 3);

        // Backpressure: pending byte is not consumed while the command is held.
        rx_byte = 8'h77;
        rx_rdy  = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("backpressure_no_clr", clr_cnt - c0, 3);
        expect_frame(8'hA5, 16'h1234);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check("ack_only_vld", 32'(cmd_vld), 0);
        check("ack_only_no_clr", 32'(clr_rx_rdy), 0);
        @(negedge clk);
        check("pending_accepted", 32'(clr_rx_rdy), 1);
        @(negedge clk);
        rx_rdy = 1'b0;
        send_byte(8'h88);
        send_byte(8'h99);
        expect_frame(8'h77, 16'h8899);
        ack_cmd();

        // Inter-byte timeout discards a partial frame.
        #1;
        f0 = frm_cnt;
        send_byte(8'h01);
        send_byte(8'h02);
        w = 1;
        while (!frm_err && w < 4 * T) begin
            @(negedge clk);
            w++;
        end
        check("frm_err_seen", 32'(frm_err), 1);
        check("timeout_cycles", w, T);
        @(negedge clk);
        check("frm_err_one_cycle", 32'(frm_err), 0);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        expect_frame(8'h0A, 16'h0B0C);
        repeat (2 * T) @(negedge clk);
        check("held_cmd_no_timeout", 32'(cmd_vld), 1);
        ack_cmd();
        repeat (3 * T) @(negedge clk);
        #1;
        check("frm_err_count", frm_cnt - f0, 1);

        // Two-byte response with an ignored request while busy, then an
        // immediate one-byte response in the first idle cycle.
        t0 = trmt_cnt;
        do_response(1'b1, 16'hBEEF, 1'b1, 1'b0);
        #1;
        check("two_byte_trmt_count", trmt_cnt - t0, 2);
        do_response(1'b0, 16'hBEEF, 1'b0, 1'b1);
        #1;
        check("one_byte_trmt_count", trmt_cnt - t0, 3);

        // Reset while a frame and a two-byte response are both in flight.
        @(negedge clk);
        resp_req  = 1'b1;
        resp_two  = 1'b1;
        resp_data = 16'hCAFE;
        @(negedge clk);
        resp_req = 1'b0;
        check("rst_pre_trmt", 32'({trmt, tx_byte}), 32'h1CA);
        @(negedge clk);
        tx_done = 1'b0;
        send_byte(8'h55);
        rx_byte = 8'h66;
        rx_rdy  = 1'b1;
        @(negedge clk);
        check("rst_pre_clr", 32'({clr_rx_rdy, resp_busy}), 3);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        t0 = trmt_cnt;
        c0 = clr_cnt;
        rx_rdy  = 1'b0;
        tx_done = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("no_stale_trmt", trmt_cnt - t0, 0);
        check("no_stale_clr", clr_cnt - c0, 0);
        check_all_zero("after_reset");
        send_byte(8'h5A);
        send_byte(8'h6B);
        send_byte(8'h7C);
        expect_frame(8'h5A, 16'h6B7C);
        ack_cmd();
        do_response(1'b1, 16'h1357, 1'b0, 1'b0);

        // Randomized concurrent RX frames and TX responses.
        for (int it = 0; it < 8; it++) begin
            logic [7:0]  b0, b1, b2;
            logic [15:0] rd;
            logic        two;
            b0  = 8'($urandom);
            b1  = 8'($urandom);
            b2  = 8'($urandom);
            rd  = 16'($urandom);
            two = 1'($urandom);
            fork
                rand_frame(b0, b1, b2);
                do_response(two, rd, 1'($urandom), 1'b0);
            join
        end

        repeat (4) @(negedge clk);
        #1;
        check("clr_never_double", clr_double, 0);
        check("frm_err_total", frm_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
